// File: rtl/gate_equiv_sequencer.sv
// Exhaustive truth-table sweep over two N-input, 1-output implementations of one function.
// It drives every minterm, waits SETTLE cycles, samples both outputs, then reports mismatches.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; results of the last sweep are held
//  DRIVE  | stim = m, settle counter runs down from SETTLE
//  SAMPLE | stim = m, capture out_a/out_b into the tables, count mismatches
//  DONE   | one-cycle done pulse, pass valid, then back to IDLE
module gate_equiv_sequencer #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic [N-1:0]      stim_o,
  input  logic              out_a_i,
  input  logic              out_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [N:0]        err_count_o,
  output logic              first_err_valid_o,
  output logic [N-1:0]      first_err_m_o,
  output logic [(1<<N)-1:0] tt_a_o,
  output logic [(1<<N)-1:0] tt_b_o
);

  localparam int NM = 1 << N;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [N-1:0]  M_LAST   = {N{1'b1}};
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NM-1:0] tt_a_q, tt_a_d;
  logic [NM-1:0] tt_b_q, tt_b_d;
  logic [N:0]    err_q, err_d;
  logic          fev_q, fev_d;
  logic [N-1:0]  fem_q, fem_d;
  logic          pass_q, pass_d;
  logic          mismatch;

  assign mismatch = out_a_i ^ out_b_i;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    tt_a_d  = tt_a_q;
    tt_b_d  = tt_b_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fem_d   = fem_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          tt_a_d  = '0;
          tt_b_d  = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fem_d   = '0;
          pass_d  = 1'b0;
          m_d     = '0;
          cnt_d   = CNT_INIT;
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        tt_a_d[m_q] = out_a_i;
        tt_b_d[m_q] = out_b_i;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fev_q) begin
            fem_d = m_q;
            fev_d = 1'b1;
          end
        end
        // last minterm found by compare so m never has to wrap
        if (m_q == M_LAST) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          m_d     = m_q + 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
      tt_a_q  <= '0;
      tt_b_q  <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fem_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      tt_a_q  <= tt_a_d;
      tt_b_q  <= tt_b_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fem_q   <= fem_d;
      pass_q  <= pass_d;
    end
  end

  // stimulus bus parks at zero outside the sweep proper
  assign stim_o            = (state_q == S_DRIVE || state_q == S_SAMPLE) ? m_q : '0;
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign pass_o            = pass_q;
  assign err_count_o       = err_q;
  assign first_err_valid_o = fev_q;
  assign first_err_m_o     = fem_q;
  assign tt_a_o            = tt_a_q;
  assign tt_b_o            = tt_b_q;

endmodule
